// File: rtl/rotate_amount_finder.sv
// rotate_amount_finder
//   Sequential inverse of the 32-bit barrel rotator. Given the original word
//   and a rotated word, it walks the candidate amounts 0..WIDTH-1, one per
//   clock, and reports the smallest amount that reproduces the rotated word.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request a search (sampled only in IDLE)
//   direction  1 = right rotate, 0 = left rotate (captured on start)
//   ref_word   original word (captured on start)
//   rot_word   rotated word to match (captured on start)
//   busy       high while searching
//   done       one-cycle pulse when found/shift_amt are valid
//   found      1 = a matching amount exists
//   shift_amt  smallest matching amount, 0 when found=0
module rotate_amount_finder #(
   parameter  int WIDTH   = 32,
   localparam int SHIFT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               direction,
   input  logic [WIDTH-1:0]   ref_word,
   input  logic [WIDTH-1:0]   rot_word,
   output logic               busy,
   output logic               done,
   output logic               found,
   output logic [SHIFT_W-1:0] shift_amt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t               state;
   logic [SHIFT_W-1:0]   k;
   logic [WIDTH-1:0]     ref_cap;
   logic [WIDTH-1:0]     rot_cap;
   logic                 dir_cap;

   // Rotation built from a doubled word: shifting {x,x} never needs a
   // WIDTH-k shift, so k=0 yields x exactly with no out-of-range artefacts.
   logic [2*WIDTH-1:0]   dbl;
   logic [2*WIDTH-1:0]   dbl_l;
   logic [2*WIDTH-1:0]   dbl_r;
   logic [WIDTH-1:0]     cand;
   logic                 hit;
   logic                 last_k;

   always_comb begin
      dbl    = {ref_cap, ref_cap};
      dbl_l  = dbl << k;
      dbl_r  = dbl >> k;
      cand   = dir_cap ? dbl_r[WIDTH-1:0] : dbl_l[2*WIDTH-1:WIDTH];
      hit    = (cand == rot_cap);
      last_k = (k == SHIFT_W'(WIDTH-1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         ref_cap   <= '0;
         rot_cap   <= '0;
         dir_cap   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         found     <= 1'b0;
         shift_amt <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  ref_cap <= ref_word;
                  rot_cap <= rot_word;
                  dir_cap <= direction;
                  k       <= '0;
                  busy    <= 1'b1;
                  state   <= SEARCH;
               end
            end
            SEARCH: begin
               // Ascending k guarantees the first hit is the smallest amount,
               // which matters for periodic words.
               if (hit) begin
                  found     <= 1'b1;
                  shift_amt <= k;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else if (last_k) begin
                  found     <= 1'b0;
                  shift_amt <= '0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               // start is deliberately not sampled here.
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
